// File: rtl/multicycle_controller.sv
// multicycle_controller
// Moore FSM that sequences an RV32I multicycle datapath (PC, OldPC, IR, A, B,
// ALUOut and Data registers, one shared ALU, one unified memory). The state
// and the decoded op/funct3/funct7b5 fields drive the datapath enables, the mux
// selects, ImmSrc and ALUControl. InstrDone pulses for one cycle in the final
// state of each retired instruction.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   op/funct3/funct7b5 instruction fields taken from IR
//   Zero              ALU result equals zero
//   MemReady          memory completes its access in this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite   datapath strobes/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl mux selects / ALU op
//   InstrDone         one-cycle pulse in an instruction's final state
//   IllegalInstr      (MC_ILLEGAL_TRAP_EN only) high while parked in TRAP
//
// Build option: define MC_ILLEGAL_TRAP_EN to trap unknown opcodes in a TRAP
// state that holds until reset. Without it, unknown opcodes retire as a NOP
// from DECODE.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       InstrDone
`ifdef MC_ILLEGAL_TRAP_EN
  ,
  output logic       IllegalInstr
`endif
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LINK     = 4'd12,
    S_LUI      = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  state_t r_state;
  state_t w_next;

  logic       w_pc_write;
  logic       w_adr_src;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic [1:0] w_result_src;
  logic [1:0] w_src_a;
  logic [1:0] w_src_b;
  logic [3:0] w_alu_ctl;
  logic       w_done;
  logic       w_op_unknown;
  logic       w_taken;

  // alt selects SUB over ADD (funct3=000) and SRA over SRL (funct3=101)
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
    logic [3:0] r;
    case (f3)
      3'b000:  r = alt ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  always_comb begin
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: w_op_unknown = 1'b0;
      default:                           w_op_unknown = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    w_next = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR;
          OP_LUI:            w_next = S_LUI;
          OP_AUIPC:          w_next = S_ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
          default:           w_next = S_TRAP;
`else
          default:           w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_JALR:     w_next = S_LINK;
      S_LINK:     w_next = S_ALUWB;
      S_LUI:      w_next = S_FETCH;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  // Branch condition: SUB for eq/ne, SLT/SLTU for the ordered compares;
  // the "greater-or-equal" forms are taken when the compare result is zero.
  always_comb begin
    w_taken = 1'b0;
    case (funct3)
      3'b000:  w_taken = Zero;
      3'b001:  w_taken = ~Zero;
      3'b100:  w_taken = ~Zero;
      3'b101:  w_taken = Zero;
      3'b110:  w_taken = ~Zero;
      3'b111:  w_taken = Zero;
      default: w_taken = 1'b0;
    endcase
  end

  // Output logic
  always_comb begin
    w_pc_write   = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_result_src = 2'b00;
    w_src_a      = 2'b00;
    w_src_b      = 2'b00;
    w_alu_ctl    = ALU_ADD;
    w_done       = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_src_b      = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = MemReady;
        w_pc_write   = MemReady;
      end
      S_DECODE: begin
        w_src_a = 2'b01;
        w_src_b = 2'b01;
`ifndef MC_ILLEGAL_TRAP_EN
        w_done  = w_op_unknown;
`endif
      end
      S_MEMADR: begin
        w_src_a = 2'b10;
        w_src_b = 2'b01;
      end
      S_MEMREAD: w_adr_src = 1'b1;
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_done       = 1'b1;
      end
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        w_done      = MemReady;
      end
      S_EXECR: begin
        w_src_a   = 2'b10;
        w_alu_ctl = alu_decode(funct3, funct7b5);
      end
      S_EXECI: begin
        w_src_a   = 2'b10;
        w_src_b   = 2'b01;
        w_alu_ctl = alu_decode(funct3, funct7b5 & (funct3 == 3'b101));
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_done      = 1'b1;
      end
      S_BRANCH: begin
        w_src_a    = 2'b10;
        w_done     = 1'b1;
        w_pc_write = w_taken;
        case (funct3)
          3'b000, 3'b001: w_alu_ctl = ALU_SUB;
          3'b100, 3'b101: w_alu_ctl = ALU_SLT;
          3'b110, 3'b111: w_alu_ctl = ALU_SLTU;
          default:        w_alu_ctl = ALU_ADD;
        endcase
      end
      S_JAL: begin
        w_pc_write = 1'b1;
        w_src_a    = 2'b01;
        w_src_b    = 2'b10;
      end
      S_JALR: begin
        w_src_a      = 2'b10;
        w_src_b      = 2'b01;
        w_result_src = 2'b10;
        w_pc_write   = 1'b1;
      end
      S_LINK: begin
        w_src_a = 2'b01;
        w_src_b = 2'b10;
      end
      S_LUI: begin
        w_result_src = 2'b11;
        w_reg_write  = 1'b1;
        w_done       = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE:         ImmSrc = 3'b001;
      OP_BRANCH:        ImmSrc = 3'b010;
      OP_JAL:           ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
      default:          ImmSrc = 3'b000;
    endcase
  end

  // Reset suppresses every architectural write combinationally, so an
  // instruction interrupted mid-flight leaves no side effects.
  assign PCWrite    = w_pc_write  & ~reset;
  assign IRWrite    = w_ir_write  & ~reset;
  assign RegWrite   = w_reg_write & ~reset;
  assign MemWrite   = w_mem_write & ~reset;
  assign InstrDone  = w_done      & ~reset;
  assign AdrSrc     = w_adr_src;
  assign ResultSrc  = w_result_src;
  assign ALUSrcA    = w_src_a;
  assign ALUSrcB    = w_src_b;
  assign ALUControl = w_alu_ctl;

`ifdef MC_ILLEGAL_TRAP_EN
  assign IllegalInstr = (r_state == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller. Each stimulus cycle pushes its
// hand-computed expected output bundle into a queue; an independent monitor
// pops and compares on the falling edge.
// Bundle layout: {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc[1:0],
//                 ALUSrcA[1:0], ALUSrcB[1:0], ImmSrc[2:0], ALUControl[3:0], InstrDone}
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, InstrDone;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       IllegalInstr;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .Zero      (Zero),
    .MemReady  (MemReady),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegWrite  (RegWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ImmSrc    (ImmSrc),
    .ALUControl(ALUControl),
    .InstrDone (InstrDone)
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    .IllegalInstr(IllegalInstr)
`endif
  );

`ifndef MC_ILLEGAL_TRAP_EN
  assign IllegalInstr = 1'b0;
`endif

  typedef struct {
    string       nm;
    logic [18:0] e;
    logic [18:0] m;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          stim_done = 1'b0;
  logic [18:0] act;

  assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ImmSrc, ALUControl, InstrDone};

  // Monitor / scoreboard: also owns the cycle budget and the summary line.
  initial begin
    exp_t        x;
    int unsigned ncyc;
    ncyc = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (q.size() != 0) begin
        x = q.pop_front();
        checks++;
        if ((act & x.m) !== (x.e & x.m)) begin
          errors++;
          $display("FAIL %s: got %b expected %b (mask %b)", x.nm, act, x.e, x.m);
        end
`ifdef MC_ILLEGAL_TRAP_EN
        checks++;
        if (IllegalInstr !== x.ill) begin
          errors++;
          $display("FAIL %s_illegal: got %b expected %b", x.nm, IllegalInstr, x.ill);
        end
`endif
      end else if (stim_done) begin
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
      if (ncyc > 2000) begin
        checks++;
        errors++;
        $display("FAIL timeout: got %0d cycles expected at most 2000", ncyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7b5 = f7;
  endtask

  task automatic cyc(input string nm, input bit rst, input bit mr, input bit z,
                     input logic [18:0] e, input logic [18:0] m = '1,
                     input bit ill = 1'b0);
    exp_t x;
    reset = rst; MemReady = mr; Zero = z;
    x.nm = nm; x.e = e; x.m = m; x.ill = ill;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; MemReady = 1'b1; Zero = 1'b0;
    instr(7'b0110011, 3'b000, 1'b0);
    @(posedge clk);
    #1;

    // Reset: first cycle only the forced-zero writes are known; then FETCH.
    cyc("rst_pre",   1, 1, 0, 19'b0, 19'b1_0_1_1_1_00_00_00_000_0000_1, 1'bx);
    cyc("rst_fetch", 1, 1, 0, 19'b0_0_0_0_0_10_00_10_000_0000_0);

    // add
    cyc("add_fetch", 0, 1, 0, 19'b1_0_0_1_0_10_00_10_000_0000_0);
    cyc("add_dec",   0, 1, 0, 19'b0_0_0_0_0_00_01_01_000_0000_0);
    cyc("add_execr", 0, 1, 0, 19'b0_0_0_0_0_00_10_00_000_0000_0);
    cyc("add_wb",    0, 1, 0, 19'b0_0_0_0_1_00_00_00_000_0000_1);

    // sub
    instr(7'b0110011, 3'b000, 1'b1);
    cyc("sub_fetch", 0, 1, 0, 19'b1_0_0_1_0_10_00_10_000_0000_0);
    cyc("sub_dec",   0, 1, 0, 19'b0_0_0_0_0_00_01_01_000_0000_0);
    cyc("sub_execr", 0, 1, 0, 19'b0_0_0_0_0_00_10_00_000_0001_0);
    cyc("sub_wb",    0, 1, 0, 19'b0_0_0_0_1_00_00_00_000_0000_1);

    // sra, with one FETCH wait cycle
    instr(7'b0110011, 3'b101, 1'b1);
    cyc("sra_fwait", 0, 0, 0, 19'b0_0_0_0_0_10_00_10_000_0000_0);
    cyc("sra_fetch", 0, 1, 0, 19'b1_0_0_1_0_10_00_10_000_0000_0);
    cyc("sra_dec",   0, 1, 0, 19'b0_0_0_0_0_00_01_01_000_0000_0);
    cyc("sra_execr", 0, 1, 0, 19'b0_0_0_0_0_00_10_00_000_1001_0);
    cyc("sra_wb",    0, 1, 0, 19'b0_0_0_0_1_00_00_00_000_0000_1);

    // addi with funct7b5=1 must stay ADD
    instr(7'b0010011, 3'b000, 1'b1);
    cyc("addi_fetch", 0, 1, 0, 19'b1_0_0_1_0_10_00_10_000_0000_0);
    cyc("addi_dec",   0, 1, 0, 19'b0_0_0_0_0_00_01_01_000_0000_0);
    cyc("addi_execi", 0, 1, 0, 19'b0_0_0_0_0_00_10_01_000_0000_0);
    cyc("addi_wb",    0, 1, 0, 19'b0_0_0_0_1_00_00_00_000_0000_1);

    // srai
    instr(7'b0010011, 3'b101, 1'b1);
    cyc("srai_fetch", 0, 1, 0, 19'b1_0_0_1_0_10_00_10_000_0000_0);
    cyc("srai_dec",   0, 1, 0, 19'b0_0_0_0_0_00_01_01_000_0000_0);
    cyc("srai_execi", 0, 1, 0, 19'b0_0_0_0_0_00_10_01_000_1001_0);
    cyc("srai_wb",    0, 1, 0, 19'b0_0_0_0_1_00_00_00_000_0000_1);

    // lw with three MEMREAD wait cycles
    instr(7'b0000011, 3'b010, 1'b0);
    cyc("lw_fetch",  0, 1, 0, 19'b1_0_0_1_0_10_00_10_000_0000_0);
    cyc("lw_dec",    0, 1, 0, 19'b0_0_0_0_0_00_01_01_000_0000_0);
    cyc("lw_memadr", 0, 1, 0, 19'b0_0_0_0_0_00_10_01_000_0000_0);
    cyc("lw_rd_w0",  0, 0, 0, 19'b0_1_0_0_0_00_00_00_000_0000_0);
    cyc("lw_rd_w1",  0, 0, 0, 19'b0_1_0_0_0_00_00_00_000_0000_0);
    cyc("lw_rd_w2",  0, 0, 0, 19'b0_1_0_0_0_00_00_00_000_0000_0);
    cyc("lw_rd_ok",  0, 1, 0, 19'b0_1_0_0_0_00_00_00_000_0000_0);
    cyc("lw_memwb",  0, 1, 0, 19'b0_0_0_0_1_01_00_00_000_0000_1);

    // sw with two MEMWRITE wait cycles
    instr(7'b0100011, 3'b010, 1'b0);
    cyc("sw_fetch",  0, 1, 0, 19'b1_0_0_1_0_10_00_10_001_0000_0);
    cyc("sw_dec",    0, 1, 0, 19'b0_0_0_0_0_00_01_01_001_0000_0);
    cyc("sw_memadr", 0, 1, 0, 19'b0_0_0_0_0_00_10_01_001_0000_0);
    cyc("sw_wr_w0",  0, 0, 0, 19'b0_1_1_0_0_00_00_00_001_0000_0);
    cyc("sw_wr_w1",  0, 0, 0, 19'b0_1_1_0_0_00_00_00_001_0000_0);
    cyc("sw_wr_ok",  0, 1, 0, 19'b0_1_1_0_0_00_00_00_001_0000_1);

    // bge taken (Zero=1) and not taken (Zero=0)
    instr(7'b1100011, 3'b101, 1'b0);
    cyc("bge_t_fetch", 0, 1, 1, 19'b1_0_0_1_0_10_00_10_010_0000_0);
    cyc("bge_t_dec",   0, 1, 1, 19'b0_0_0_0_0_00_01_01_010_0000_0);
    cyc("bge_t_br",    0, 1, 1, 19'b1_0_0_0_0_00_10_00_010_0101_1);
    cyc("bge_n_fetch", 0, 1, 0, 19'b1_0_0_1_0_10_00_10_010_0000_0);
    cyc("bge_n_dec",   0, 1, 0, 19'b0_0_0_0_0_00_01_01_010_0000_0);
    cyc("bge_n_br",    0, 1, 0, 19'b0_0_0_0_0_00_10_00_010_0101_1);

    // bne taken on Zero=0
    instr(7'b1100011, 3'b001, 1'b0);
    cyc("bne_fetch", 0, 1, 0, 19'b1_0_0_1_0_10_00_10_010_0000_0);
    cyc("bne_dec",   0, 1, 0, 19'b0_0_0_0_0_00_01_01_010_0000_0);
    cyc("bne_br",    0, 1, 0, 19'b1_0_0_0_0_00_10_00_010_0001_1);

    // jal
    instr(7'b1101111, 3'b000, 1'b0);
    cyc("jal_fetch", 0, 1, 0, 19'b1_0_0_1_0_10_00_10_011_0000_0);
    cyc("jal_dec",   0, 1, 0, 19'b0_0_0_0_0_00_01_01_011_0000_0);
    cyc("jal_jal",   0, 1, 0, 19'b1_0_0_0_0_00_01_10_011_0000_0);
    cyc("jal_wb",    0, 1, 0, 19'b0_0_0_0_1_00_00_00_011_0000_1);

    // jalr
    instr(7'b1100111, 3'b000, 1'b0);
    cyc("jalr_fetch", 0, 1, 0, 19'b1_0_0_1_0_10_00_10_000_0000_0);
    cyc("jalr_dec",   0, 1, 0, 19'b0_0_0_0_0_00_01_01_000_0000_0);
    cyc("jalr_jalr",  0, 1, 0, 19'b1_0_0_0_0_10_10_01_000_0000_0);
    cyc("jalr_link",  0, 1, 0, 19'b0_0_0_0_0_00_01_10_000_0000_0);
    cyc("jalr_wb",    0, 1, 0, 19'b0_0_0_0_1_00_00_00_000_0000_1);

    // jalr aborted by reset in LINK: next cycle is FETCH, no register write
    cyc("jalr2_fetch", 0, 1, 0, 19'b1_0_0_1_0_10_00_10_000_0000_0);
    cyc("jalr2_dec",   0, 1, 0, 19'b0_0_0_0_0_00_01_01_000_0000_0);
    cyc("jalr2_jalr",  0, 1, 0, 19'b1_0_0_0_0_10_10_01_000_0000_0);
    cyc("jalr2_rst",   1, 1, 0, 19'b0_0_0_0_0_00_01_10_000_0000_0);
    cyc("jalr2_after", 0, 1, 0, 19'b1_0_0_1_0_10_00_10_000_0000_0);
    cyc("jalr2_dec2",  0, 1, 0, 19'b0_0_0_0_0_00_01_01_000_0000_0);
    cyc("jalr2_jalr2", 0, 1, 0, 19'b1_0_0_0_0_10_10_01_000_0000_0);
    cyc("jalr2_link2", 0, 1, 0, 19'b0_0_0_0_0_00_01_10_000_0000_0);
    cyc("jalr2_wb",    0, 1, 0, 19'b0_0_0_0_1_00_00_00_000_0000_1);

    // lui
    instr(7'b0110111, 3'b000, 1'b0);
    cyc("lui_fetch", 0, 1, 0, 19'b1_0_0_1_0_10_00_10_100_0000_0);
    cyc("lui_dec",   0, 1, 0, 19'b0_0_0_0_0_00_01_01_100_0000_0);
    cyc("lui_lui",   0, 1, 0, 19'b0_0_0_0_1_11_00_00_100_0000_1);

    // auipc goes straight from DECODE to ALUWB
    instr(7'b0010111, 3'b000, 1'b0);
    cyc("auipc_fetch", 0, 1, 0, 19'b1_0_0_1_0_10_00_10_100_0000_0);
    cyc("auipc_dec",   0, 1, 0, 19'b0_0_0_0_0_00_01_01_100_0000_0);
    cyc("auipc_wb",    0, 1, 0, 19'b0_0_0_0_1_00_00_00_100_0000_1);

    // unknown opcode
    instr(7'b1111111, 3'b000, 1'b0);
    cyc("ill_fetch", 0, 1, 0, 19'b1_0_0_1_0_10_00_10_000_0000_0);
`ifdef MC_ILLEGAL_TRAP_EN
    cyc("ill_dec",   0, 1, 0, 19'b0_0_0_0_0_00_01_01_000_0000_0);
    cyc("ill_trap0", 0, 1, 0, 19'b0, '1, 1'b1);
    cyc("ill_trap1", 0, 1, 0, 19'b0, '1, 1'b1);
    cyc("ill_trap2", 0, 1, 0, 19'b0, '1, 1'b1);
    cyc("ill_rst",   1, 1, 0, 19'b0, '1, 1'b1);
`else
    cyc("ill_dec",   0, 1, 0, 19'b0_0_0_0_0_00_01_01_000_0000_1);
`endif
    instr(7'b0110011, 3'b000, 1'b0);
    cyc("ill_after", 0, 1, 0, 19'b1_0_0_1_0_10_00_10_000_0000_0);
    cyc("ill_dec2",  0, 1, 0, 19'b0_0_0_0_0_00_01_01_000_0000_0);

    stim_done = 1'b1;
  end

endmodule
